// File: rtl/input_conditioner.sv
// input_conditioner: synchronise and debounce buttons and sw[0],
// emit press pulses and a long-hold trigger for sw[0].
module input_conditioner #(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 4000
) (
  input  logic clk,
  input  logic notReset,
  input  logic btnL_raw,
  input  logic btnR_raw,
  input  logic btnC_raw,
  input  logic sw0_raw,
  output logic btnL,
  output logic btnR,
  output logic btnC,
  output logic btnL_press,
  output logic btnR_press,
  output logic btnC_press,
  output logic B2_trigger
);

  localparam int TW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    OFF,
    COUNTING,
    ARMED
  } hold_e;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // bit order: 0=L, 1=R, 2=C, 3=sw0
  logic [3:0]    raw;
  logic [3:0]    sync_q1;
  logic [3:0]    sync_q2;
  logic [3:0]    level;
  logic [2:0]    level_d;
  logic [DW-1:0] db_cnt [4];

  assign raw = {sw0_raw, btnC_raw, btnR_raw, btnL_raw};

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      level_d <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      level_d <= level[2:0];
    end
  end

  // a matching sample on any tick restarts the window
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      level <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] ==
                     DW'(DEBOUNCE_TICKS - 1)) begin
          level[i]  <= sync_q2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btnL = level[0];
  assign btnR = level[1];
  assign btnC = level[2];

  assign btnL_press = level[0] & ~level_d[0];
  assign btnR_press = level[1] & ~level_d[1];
  assign btnC_press = level[2] & ~level_d[2];

  logic          sw0_db;
  hold_e         state;
  hold_e         state_n;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_n;

  assign sw0_db = level[3];

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state      <= OFF;
      hold_cnt   <= '0;
      B2_trigger <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      B2_trigger <= (state_n == ARMED);
    end
  end

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    unique case (state)
      OFF: begin
        hold_cnt_n = '0;
        if (sw0_db) begin
          state_n = COUNTING;
        end
      end
      COUNTING: begin
        if (!sw0_db) begin
          state_n    = OFF;
          hold_cnt_n = '0;
        end else if (tick) begin
          hold_cnt_n = hold_cnt + 1'b1;
          if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
            state_n = ARMED;
          end
        end
      end
      ARMED: begin
        if (!sw0_db) begin
          state_n    = OFF;
          hold_cnt_n = '0;
        end
      end
      default: begin
        state_n    = OFF;
        hold_cnt_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random checks of input_conditioner
// against a tick-sampled reference model.
module tb_input_conditioner;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int HT = 10;

  logic clk = 1'b0;
  logic notReset = 1'b0;
  logic btnL_raw = 1'b0;
  logic btnR_raw = 1'b0;
  logic btnC_raw = 1'b0;
  logic sw0_raw = 1'b0;
  logic btnL, btnR, btnC;
  logic btnL_press, btnR_press, btnC_press;
  logic B2_trigger;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DB),
    .HOLD_TICKS    (HT)
  ) dut (
    .clk       (clk),
    .notReset  (notReset),
    .btnL_raw  (btnL_raw),
    .btnR_raw  (btnR_raw),
    .btnC_raw  (btnC_raw),
    .sw0_raw   (sw0_raw),
    .btnL      (btnL),
    .btnR      (btnR),
    .btnC      (btnC),
    .btnL_press(btnL_press),
    .btnR_press(btnR_press),
    .btnC_press(btnC_press),
    .B2_trigger(B2_trigger)
  );

  logic [6:0] dut_v;
  assign dut_v = {btnC, btnR, btnL,
                  btnC_press, btnR_press, btnL_press,
                  B2_trigger};

  // reference model: edge index m_e counts clocks since reset release
  logic [3:0] raw_v;
  logic [3:0] m_lvl, m_s1, m_s2;
  logic [2:0] m_press;
  logic       m_b2;
  int         m_e, m_rise;
  bit         hist [4][DB];
  int         nfill [4];
  logic [6:0] m_v;

  assign raw_v = {sw0_raw, btnC_raw, btnR_raw, btnL_raw};
  assign m_v = {m_lvl[2:0], m_press, m_b2};

  always @(posedge clk or negedge notReset) begin : model
    logic [3:0] old;
    bit tk, all_diff;
    if (!notReset) begin
      m_lvl = '0; m_s1 = '0; m_s2 = '0;
      m_press = '0; m_b2 = 1'b0;
      m_e = 0; m_rise = 0;
      for (int i = 0; i < 4; i++) nfill[i] = 0;
    end else begin
      old = m_lvl;
      tk = (m_e % TD) == TD - 1;
      if (tk) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < DB - 1; j++)
            hist[i][j] = hist[i][j+1];
          hist[i][DB-1] = m_s2[i];
          if (nfill[i] < DB) nfill[i]++;
          all_diff = 1'b1;
          for (int j = 0; j < DB; j++)
            if (hist[i][j] == old[i]) all_diff = 1'b0;
          if (nfill[i] == DB && all_diff) m_lvl[i] = m_s2[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_v;
      m_press = m_lvl[2:0] & ~old[2:0];
      // ticks strictly after the edge following the sw0 rise
      m_b2 = old[3] &&
             ((m_e + 1) / TD - (m_rise + 2) / TD >= HT);
      if (m_lvl[3] && !old[3]) m_rise = m_e;
      m_e++;
    end
  end

  // edge at which a raw change made before edge p is debounced
  function automatic int db_edge(int p);
    int t1;
    t1 = p + 2 + (TD - 1 - (p + 2) % TD);
    return t1 + (DB - 1) * TD;
  endfunction

  task automatic test_reset();
    int k;
    int np [3];
    {sw0_raw, btnC_raw, btnR_raw, btnL_raw} = 4'hF;
    repeat (30) @(negedge clk);
    n_tests++;
    if (dut_v !== m_v) begin
      n_fail++;
      $display("FAIL reset_pre got=%b want=%b", dut_v, m_v);
    end
    #2 notReset = 1'b0;
    #1;
    n_tests++;
    if (dut_v !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_async got=%b want=0", dut_v);
    end
    @(negedge clk);
    notReset = 1'b1;
    k = -1;
    np = '{0, 0, 0};
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== m_v) begin
        n_fail++;
        $display("FAIL reset_model c=%0d got=%b want=%b",
                 c, dut_v, m_v);
      end
      if (k < 0 && btnL) k = c;
      np[0] += int'(btnL_press);
      np[1] += int'(btnR_press);
      np[2] += int'(btnC_press);
    end
    n_tests++;
    if (k != db_edge(0) + 1) begin
      n_fail++;
      $display("FAIL reset_rise got=%0d want=%0d",
               k, db_edge(0) + 1);
    end
    n_tests++;
    if (np[0] != 1 || np[1] != 1 || np[2] != 1) begin
      n_fail++;
      $display("FAIL reset_press got=%0d/%0d/%0d want=1/1/1",
               np[0], np[1], np[2]);
    end
    {sw0_raw, btnC_raw, btnR_raw, btnL_raw} = 4'h0;
    repeat (10 * TD) @(negedge clk);
  endtask

  task automatic test_glitch();
    int dur [5];
    bit val [5];
    int np, early;
    dur = '{2 * TD, TD, 2 * TD, 2 * TD, 4 * TD};
    val = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    np = 0;
    early = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      btnC_raw = val[p];
      repeat (dur[p]) begin
        @(negedge clk);
        n_tests++;
        if (dut_v !== m_v) begin
          n_fail++;
          $display("FAIL glitch_model p=%0d got=%b want=%b",
                   p, dut_v, m_v);
        end
        if (p < 4 && (btnC || btnC_press)) early++;
        np += int'(btnC_press);
      end
    end
    n_tests++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL glitch_reject got=%0d want=0", early);
    end
    n_tests++;
    if (np != 1 || btnC !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_press got=%0d,%b want=1,1",
               np, btnC);
    end
    btnC_raw = 1'b0;
    repeat (6 * TD) @(negedge clk);
  endtask

  task automatic test_release();
    int np [3];
    bit v [3];
    v = '{1'b1, 1'b0, 1'b1};
    repeat ($urandom_range(0, 3)) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      btnL_raw = v[p];
      np[p] = 0;
      repeat (5 * TD) begin
        @(negedge clk);
        n_tests++;
        if (dut_v !== m_v) begin
          n_fail++;
          $display("FAIL release_model p=%0d got=%b want=%b",
                   p, dut_v, m_v);
        end
        np[p] += int'(btnL_press);
      end
      n_tests++;
      if (btnL !== v[p]) begin
        n_fail++;
        $display("FAIL release_level p=%0d got=%b want=%b",
                 p, btnL, v[p]);
      end
    end
    n_tests++;
    if (np[0] != 1 || np[1] != 0 || np[2] != 1) begin
      n_fail++;
      $display("FAIL release_press got=%0d/%0d/%0d want=1/0/1",
               np[0], np[1], np[2]);
    end
    btnL_raw = 1'b0;
    repeat (6 * TD) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int pl, pr, both;
    pl = 0; pr = 0; both = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    btnL_raw = 1'b1;
    btnR_raw = 1'b1;
    repeat (5 * TD) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== m_v) begin
        n_fail++;
        $display("FAIL simul_model got=%b want=%b", dut_v, m_v);
      end
      pl += int'(btnL_press);
      pr += int'(btnR_press);
      both += int'(btnL_press && btnR_press);
    end
    n_tests++;
    if (pl != 1 || pr != 1 || both != 1) begin
      n_fail++;
      $display("FAIL simul_press got=%0d/%0d/%0d want=1/1/1",
               pl, pr, both);
    end
    btnL_raw = 1'b0;
    btnR_raw = 1'b0;
    repeat (6 * TD) @(negedge clk);
  endtask

  task automatic test_hold();
    int exp_on, exp_off, on_e, off_e, drops;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    exp_on = db_edge(m_e) + HT * TD;
    sw0_raw = 1'b1;
    on_e = -1;
    for (int c = 0; c < 400 && on_e < 0; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== m_v) begin
        n_fail++;
        $display("FAIL hold_model got=%b want=%b", dut_v, m_v);
      end
      if (B2_trigger) on_e = m_e - 1;
    end
    n_tests++;
    if (on_e != exp_on) begin
      n_fail++;
      $display("FAIL hold_on got=%0d want=%0d", on_e, exp_on);
    end
    drops = 0;
    repeat (20 * TD) begin
      @(negedge clk);
      if (!B2_trigger) drops++;
    end
    n_tests++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL hold_stay got=%0d want=0", drops);
    end
    exp_off = db_edge(m_e) + 1;
    sw0_raw = 1'b0;
    off_e = -1;
    for (int c = 0; c < 100 && off_e < 0; c++) begin
      @(negedge clk);
      if (!B2_trigger) off_e = m_e - 1;
    end
    n_tests++;
    if (off_e != exp_off) begin
      n_fail++;
      $display("FAIL hold_off got=%0d want=%0d", off_e, exp_off);
    end
    repeat (5 * TD) @(negedge clk);
  endtask

  task automatic test_abort_reset();
    int highs, exp_on, on_e, target;
    highs = 0;
    sw0_raw = 1'b1;
    repeat (6 * TD) @(negedge clk);
    sw0_raw = 1'b0;
    repeat (8 * TD) begin
      @(negedge clk);
      highs += int'(B2_trigger);
    end
    n_tests++;
    if (highs != 0) begin
      n_fail++;
      $display("FAIL abort_none got=%0d want=0", highs);
    end
    exp_on = db_edge(m_e) + HT * TD;
    sw0_raw = 1'b1;
    on_e = -1;
    for (int c = 0; c < 400 && on_e < 0; c++) begin
      @(negedge clk);
      if (B2_trigger) on_e = m_e - 1;
    end
    n_tests++;
    if (on_e != exp_on) begin
      n_fail++;
      $display("FAIL abort_full got=%0d want=%0d", on_e, exp_on);
    end
    sw0_raw = 1'b0;
    repeat (8 * TD) @(negedge clk);
    target = db_edge(m_e) + 1 + 8 * TD;
    sw0_raw = 1'b1;
    while (m_e <= target) @(negedge clk);
    n_tests++;
    if (B2_trigger !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre got=%b want=0", B2_trigger);
    end
    #2 notReset = 1'b0;
    #1;
    n_tests++;
    if (dut_v !== 7'b0) begin
      n_fail++;
      $display("FAIL abort_rst got=%b want=0", dut_v);
    end
    @(negedge clk);
    notReset = 1'b1;
    exp_on = db_edge(0) + HT * TD;
    on_e = -1;
    for (int c = 0; c < 400 && on_e < 0; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== m_v) begin
        n_fail++;
        $display("FAIL abort_model got=%b want=%b", dut_v, m_v);
      end
      if (B2_trigger) on_e = m_e - 1;
    end
    n_tests++;
    if (on_e != exp_on) begin
      n_fail++;
      $display("FAIL abort_restart got=%0d want=%0d",
               on_e, exp_on);
    end
    sw0_raw = 1'b0;
    repeat (6 * TD) @(negedge clk);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 150; r++) begin
      {sw0_raw, btnC_raw, btnR_raw, btnL_raw} = 4'($urandom);
      if ($urandom_range(0, 3) == 0)
        n = $urandom_range(3 * TD, 60 * TD);
      else
        n = $urandom_range(1, 3 * TD);
      repeat (n) begin
        @(negedge clk);
        n_tests++;
        if (dut_v !== m_v) begin
          n_fail++;
          $display("FAIL random_model r=%0d got=%b want=%b",
                   r, dut_v, m_v);
        end
      end
      if ($urandom_range(0, 29) == 0) begin
        #2 notReset = 1'b0;
        #1;
        n_tests++;
        if (dut_v !== 7'b0) begin
          n_fail++;
          $display("FAIL random_rst got=%b want=0", dut_v);
        end
        @(negedge clk);
        notReset = 1'b1;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    notReset = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_glitch();
    test_release();
    test_simultaneous();
    test_hold();
    test_abort_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage for the OLED pixel generator. Synchronises and debounces raw pushbuttons btnL/btnR/btnC and switch sw[0].
- Emits clean levels and single-clock press pulses for the three buttons.
- Emits B2_trigger, which asserts after sw[0] has been continuously on for 4 s.
- Runs on the 100 MHz board clock, with an internally generated 1 ms tick.

Parameters:
- TICK_DIV, 100000: clk cycles per tick (1 ms at 100 MHz).
- DEBOUNCE_TICKS, 20: consecutive ticks an input must differ from its debounced level before the level changes.
- HOLD_TICKS, 4000: ticks sw[0] must stay debounced-high before B2_trigger asserts.

Ports:
- clk, input, 1: 100 MHz system clock.
- notReset, input, 1: asynchronous active-low reset.
- btnL_raw, input, 1: raw left button.
- btnR_raw, input, 1: raw right button.
- btnC_raw, input, 1: raw centre button.
- sw0_raw, input, 1: raw switch 0.
- btnL, output, 1: debounced left level.
- btnR, output, 1: debounced right level.
- btnC, output, 1: debounced centre level.
- btnL_press, output, 1: one-clk pulse on debounced rise of btnL.
- btnR_press, output, 1: one-clk pulse on debounced rise of btnR.
- btnC_press, output, 1: one-clk pulse on debounced rise of btnC.
- B2_trigger, output, 1: high while sw[0] has been held for at least HOLD_TICKS.

Behaviour:
- Reset: asynchronous, notReset=0. While low, all synchroniser flops, debounced levels, pulses, counters and B2_trigger are 0, and the hold FSM is OFF. Reset may occur at any time, including mid-debounce or mid-hold; no residual count survives it.
- Synchroniser: 2-flop chain per raw input, reset to 0. Input-to-sync latency is 2 clk.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly one clk when tick_cnt==TICK_DIV-1.
  - Counter width is clog2(TICK_DIV).
- Debouncer, one identical instance per input (4 total):
  - Per-input counter db_cnt, width clog2(DEBOUNCE_TICKS+1).
  - On a tick with sync!=level: db_cnt increments. When db_cnt reaches DEBOUNCE_TICKS-1 on that tick, level<=sync and db_cnt<=0.
  - On a tick with sync==level: db_cnt<=0. A single-tick glitch therefore restarts the count.
  - Between ticks, level and db_cnt hold.
  - Press and release are debounced symmetrically.
- Press pulse:
  - *_press = level & ~level_d, where level_d is level registered 1 clk later. Exactly one clk wide.
  - Nothing is emitted on release.
  - Buttons are independent. Simultaneous debounced rises produce simultaneous pulses; priority is the consumer's job.
- Hold FSM on sw0 debounced level (sw0_db), counter hold_cnt with width clog2(HOLD_TICKS+1):
  - OFF: B2_trigger=0, hold_cnt=0. If sw0_db=1, go to COUNTING.
  - COUNTING:
    - If sw0_db=0, go to OFF and clear hold_cnt. A drop takes precedence over a same-cycle tick.
    - Otherwise hold_cnt increments on each tick.
    - On the tick where hold_cnt==HOLD_TICKS-1, go to ARMED.
  - ARMED: B2_trigger=1 and hold_cnt frozen. If sw0_db=0, go to OFF; B2_trigger drops the following clk.
- B2_trigger is a registered state decode (ARMED), so it is glitch-free.
- Boundary: sw0 bouncing shorter than the debounce window does not disturb COUNTING. hold_cnt never wraps, since ARMED freezes it.

Test Plan:
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, HOLD_TICKS=10.
1. Reset: notReset=0 with all raw inputs 1 -> all outputs 0 immediately (asynchronous). Release reset -> btnL/btnR/btnC rise after 2 clk plus 3 ticks, with exactly one *_press pulse each.
2. Glitch rejection: btnC_raw high for 2 ticks, low 1 tick, high 2 ticks -> btnC stays 0 and no pulse. Then hold high for 3 ticks -> btnC=1 and btnC_press high for exactly 1 clk.
3. Release: btnL debounced high, then btnL_raw=0 for 3 ticks -> btnL=0 and no press pulse. Re-press -> exactly one new btnL_press.
4. Simultaneous: btnL_raw and btnR_raw rise in the same clk -> btnL_press and btnR_press asserted in the same clk, each 1 clk wide.
5. Hold: sw0_raw=1 steady -> B2_trigger=1 exactly 10 ticks after sw0_db rises. Hold 20 more ticks -> stays 1. sw0_raw=0 -> B2_trigger=0 one clk after sw0_db falls.
6. Abort and reset mid-hold: sw0 on for 6 ticks then off -> B2_trigger never asserts. Turn it on again -> full 10 ticks are required. Assert notReset=0 at tick 8 -> B2_trigger stays 0, and a restart needs 10 ticks.
